game_flow_controller: RTL and testbench
=======================================

Name: game_flow_controller

Overview:
Top-level game sequencer for the Frogger datapath. Counts lives and levels and gates frog/car activity through countdown, death-freeze, level-clear and game-over phases. Sits between the debounced switches and collision/level-up sources on one side and Character_Control, Obstacles_Movement and the score display on the other. Replaces the two-state IDLE/RUNNING loop in the game top.

Parameters:
C_LIVES_INI, 3, lives loaded on game start; legal range 1..7.
C_COUNTDOWN_FRAMES, 120, frames spent in COUNTDOWN before play; must be >=1.
C_FREEZE_FRAMES, 60, frames spent in DYING or LEVEL_CLEAR; must be >=1.
C_LEVEL_MAX, 9, saturation value of o_Level; legal range 1..15.

Ports:
i_Clk  in  1  system clock
i_Rst_L  in  1  reset; synchronous, active-low
i_Frame_Tick  in  1  one-cycle pulse per video frame
i_All_Switch  in  1  all four debounced switches pressed
i_Has_Collided  in  1  frog/car collision, level-sensitive
i_Level_Up  in  1  one-cycle pulse when the frog reaches the top row
o_Game_Active  out  1  high only in RUNNING; drives Character_Control i_Game_Active
o_Respawn  out  1  one-cycle pulse; frog returns to its base position
o_Freeze  out  1  high in DYING and LEVEL_CLEAR; cars hold position
o_Game_Over  out  1  high in GAME_OVER
o_Lives  out  3  remaining lives
o_Level  out  4  current level, 0-based
o_State  out  3  state encoding, for debug

Behaviour:
- All outputs are registered. Each output reflects the new state on the cycle after the clock edge that takes the transition.
- Reset (i_Rst_L=0 at posedge) forces the following, overriding any operation in progress:
  - state IDLE, frame counter 0, r_All_Switch_d=1;
  - o_Game_Active=0, o_Respawn=0, o_Freeze=0, o_Game_Over=0;
  - o_Lives=C_LIVES_INI, o_Level=0.
- Start edge: w_Start = i_All_Switch & ~r_All_Switch_d. Because r_All_Switch_d resets to 1, holding the switches through reset does not start a game.
- Frame counter: width covers max(C_COUNTDOWN_FRAMES, C_FREEZE_FRAMES). It decrements only on i_Frame_Tick. A phase expires on a tick that arrives while the counter is 1.
- States: IDLE=0, COUNTDOWN=1, RUNNING=2, DYING=3, LEVEL_CLEAR=4, GAME_OVER=5. Encodings 6 and 7 go to IDLE.
- IDLE:
  - hold o_Lives=C_LIVES_INI and o_Level=0;
  - on w_Start go to COUNTDOWN, load C_COUNTDOWN_FRAMES, pulse o_Respawn.
- COUNTDOWN: on expiry go to RUNNING.
- RUNNING (o_Game_Active=1):
  - i_Has_Collided=1: decrement o_Lives. If o_Lives was 1, go to GAME_OVER with o_Lives=0. Otherwise go to DYING and load C_FREEZE_FRAMES.
  - Otherwise, i_Level_Up=1: go to LEVEL_CLEAR and load C_FREEZE_FRAMES. o_Level increments, saturating at C_LEVEL_MAX.
  - If both are asserted in the same cycle, the collision wins and the level-up is dropped.
- DYING and LEVEL_CLEAR: on expiry go to COUNTDOWN, reload C_COUNTDOWN_FRAMES, pulse o_Respawn.
- GAME_OVER: on w_Start go to IDLE. A new game needs another w_Start, so two distinct presses are required.
- i_Has_Collided and i_Level_Up are ignored outside RUNNING. i_Frame_Tick is ignored in IDLE, RUNNING and GAME_OVER.
- o_Respawn is exactly one cycle long and only occurs on entry to COUNTDOWN.
- o_Lives never underflows. o_Level never exceeds C_LEVEL_MAX.

Optional Feature:
Macro: FROGGER_EXTRA_LIFE_EN.
- Defined: on the RUNNING->LEVEL_CLEAR transition, if the new o_Level is a nonzero multiple of 3, o_Lives increments, saturating at 7. This happens in the same cycle as the level increment.
- Undefined: o_Lives only ever decrements after start. No extra logic is generated.

Test Plan:
Test parameters for all scenarios: C_LIVES_INI=3, C_COUNTDOWN_FRAMES=4, C_FREEZE_FRAMES=2, C_LEVEL_MAX=2.
1. Reset with i_All_Switch held high, release, then press -> no start while held; after the press, o_State=1 and one o_Respawn pulse; after 4 ticks, o_Game_Active=1.
2. In RUNNING, assert collision three times, letting each freeze and countdown elapse -> o_Lives goes 2, 1, 0; o_State goes 3 twice, then 5; o_Game_Over=1.
3. In RUNNING, assert i_Level_Up three times -> o_Level goes 1, 2, 2 (saturated); o_Freeze high for exactly 2 ticks each time.
4. Collision and level-up in the same cycle -> o_State=3, o_Lives=2, o_Level unchanged.
5. In GAME_OVER, press (start edge), release, press -> first press goes to IDLE (o_Lives=3, o_Level=0); second press goes to COUNTDOWN.
6. Reset asserted mid-COUNTDOWN after 2 ticks -> next cycle all outputs at reset values; later ticks have no effect.

Source files
------------

// File: rtl/game_flow_controller.sv
// Game flow sequencer for the Frogger datapath.
// Tracks lives and levels and gates frog/car activity through the
// COUNTDOWN, RUNNING, DYING, LEVEL_CLEAR and GAME_OVER phases.
//
// Optional feature macro: FROGGER_EXTRA_LIFE_EN
//   When defined, reaching a nonzero level that is a multiple of 3 awards one
//   extra life (saturating at 7). When undefined, no extra logic is built.
//
// Ports:
//   i_Clk          system clock
//   i_Rst_L        synchronous active-low reset
//   i_Frame_Tick   one-cycle pulse per video frame
//   i_All_Switch   all four debounced switches pressed
//   i_Has_Collided frog/car collision (level-sensitive)
//   i_Level_Up     one-cycle pulse when the frog reaches the top row
//   o_Game_Active  high only in RUNNING
//   o_Respawn      one-cycle pulse on entry to COUNTDOWN
//   o_Freeze       high in DYING and LEVEL_CLEAR
//   o_Game_Over    high in GAME_OVER
//   o_Lives        remaining lives
//   o_Level        current level, 0-based
//   o_State        state encoding, for debug
module game_flow_controller #(
    parameter int unsigned C_LIVES_INI        = 3,
    parameter int unsigned C_COUNTDOWN_FRAMES = 120,
    parameter int unsigned C_FREEZE_FRAMES    = 60,
    parameter int unsigned C_LEVEL_MAX        = 9
) (
    input  logic       i_Clk,
    input  logic       i_Rst_L,
    input  logic       i_Frame_Tick,
    input  logic       i_All_Switch,
    input  logic       i_Has_Collided,
    input  logic       i_Level_Up,
    output logic       o_Game_Active,
    output logic       o_Respawn,
    output logic       o_Freeze,
    output logic       o_Game_Over,
    output logic [2:0] o_Lives,
    output logic [3:0] o_Level,
    output logic [2:0] o_State
);

    localparam int unsigned CNT_MAX = (C_COUNTDOWN_FRAMES > C_FREEZE_FRAMES) ?
                                      C_COUNTDOWN_FRAMES : C_FREEZE_FRAMES;
    localparam int unsigned CNT_W   = $clog2(CNT_MAX + 1);

    localparam logic [CNT_W-1:0] CD_LOAD     = CNT_W'(C_COUNTDOWN_FRAMES);
    localparam logic [CNT_W-1:0] FREEZE_LOAD = CNT_W'(C_FREEZE_FRAMES);
    localparam logic [CNT_W-1:0] CNT_ONE     = CNT_W'(1);
    localparam logic [2:0]       LIVES_INI   = 3'(C_LIVES_INI);
    localparam logic [3:0]       LEVEL_MAX   = 4'(C_LEVEL_MAX);

    typedef enum logic [2:0] {
        ST_IDLE        = 3'd0,
        ST_COUNTDOWN   = 3'd1,
        ST_RUNNING     = 3'd2,
        ST_DYING       = 3'd3,
        ST_LEVEL_CLEAR = 3'd4,
        ST_GAME_OVER   = 3'd5
    } state_t;

    state_t           state;
    logic [CNT_W-1:0] frame_cnt;
    logic             all_switch_d;

    logic             start_c;
    logic             expire_c;
    logic [3:0]       level_next_c;

    // Rising edge of the switch combo; the delay flop resets high so a
    // press held through reset is not taken as a start.
    assign start_c      = i_All_Switch & ~all_switch_d;
    // A timed phase ends on the tick that finds the counter at 1.
    assign expire_c     = i_Frame_Tick & (frame_cnt == CNT_ONE);
    assign level_next_c = (o_Level < LEVEL_MAX) ? (o_Level + 4'd1) : o_Level;
    assign o_State      = state;

`ifdef FROGGER_EXTRA_LIFE_EN
    logic extra_life_c;
    assign extra_life_c = (level_next_c != 4'd0) &&
                          ((level_next_c % 4'd3) == 4'd0) &&
                          (o_Lives != 3'd7);
`endif

    // Sequencer: state, frame counter and all registered outputs.
    always_ff @(posedge i_Clk) begin
        if (!i_Rst_L) begin
            state         <= ST_IDLE;
            frame_cnt     <= '0;
            all_switch_d  <= 1'b1;
            o_Game_Active <= 1'b0;
            o_Respawn     <= 1'b0;
            o_Freeze      <= 1'b0;
            o_Game_Over   <= 1'b0;
            o_Lives       <= LIVES_INI;
            o_Level       <= 4'd0;
        end else begin
            all_switch_d <= i_All_Switch;
            o_Respawn    <= 1'b0;

            case (state)
                ST_IDLE: begin
                    o_Lives <= LIVES_INI;
                    o_Level <= 4'd0;
                    if (start_c) begin
                        state     <= ST_COUNTDOWN;
                        frame_cnt <= CD_LOAD;
                        o_Respawn <= 1'b1;
                    end
                end

                ST_COUNTDOWN: begin
                    if (expire_c) begin
                        state         <= ST_RUNNING;
                        frame_cnt     <= '0;
                        o_Game_Active <= 1'b1;
                    end else if (i_Frame_Tick) begin
                        frame_cnt <= frame_cnt - CNT_ONE;
                    end
                end

                ST_RUNNING: begin
                    // Collision has priority; a simultaneous level-up is dropped.
                    if (i_Has_Collided) begin
                        o_Game_Active <= 1'b0;
                        if (o_Lives <= 3'd1) begin
                            state       <= ST_GAME_OVER;
                            o_Lives     <= 3'd0;
                            o_Game_Over <= 1'b1;
                        end else begin
                            state     <= ST_DYING;
                            o_Lives   <= o_Lives - 3'd1;
                            frame_cnt <= FREEZE_LOAD;
                            o_Freeze  <= 1'b1;
                        end
                    end else if (i_Level_Up) begin
                        state         <= ST_LEVEL_CLEAR;
                        frame_cnt     <= FREEZE_LOAD;
                        o_Game_Active <= 1'b0;
                        o_Freeze      <= 1'b1;
                        o_Level       <= level_next_c;
`ifdef FROGGER_EXTRA_LIFE_EN
                        if (extra_life_c) begin
                            o_Lives <= o_Lives + 3'd1;
                        end
`endif
                    end
                end

                ST_DYING, ST_LEVEL_CLEAR: begin
                    if (expire_c) begin
                        state     <= ST_COUNTDOWN;
                        frame_cnt <= CD_LOAD;
                        o_Freeze  <= 1'b0;
                        o_Respawn <= 1'b1;
                    end else if (i_Frame_Tick) begin
                        frame_cnt <= frame_cnt - CNT_ONE;
                    end
                end

                ST_GAME_OVER: begin
                    // Back to IDLE only; a second press is needed to play.
                    if (start_c) begin
                        state       <= ST_IDLE;
                        o_Game_Over <= 1'b0;
                        o_Lives     <= LIVES_INI;
                        o_Level     <= 4'd0;
                    end
                end

                default: begin
                    state         <= ST_IDLE;
                    frame_cnt     <= '0;
                    o_Game_Active <= 1'b0;
                    o_Freeze      <= 1'b0;
                    o_Game_Over   <= 1'b0;
                    o_Lives       <= LIVES_INI;
                    o_Level       <= 4'd0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_game_flow_controller.sv
// Directed self-checking bench for game_flow_controller.
// Small parameter set: 3 lives, 4-frame countdown, 2-frame freeze, level max 2.
module tb_game_flow_controller;

    logic       clk;
    logic       rst_n;
    logic       frame_tick;
    logic       all_switch;
    logic       has_collided;
    logic       level_up;
    logic       game_active;
    logic       respawn;
    logic       freeze;
    logic       game_over;
    logic [2:0] lives;
    logic [3:0] level;
    logic [2:0] state;

    int n_checks = 0;
    int n_errors = 0;

    game_flow_controller #(
        .C_LIVES_INI        (3),
        .C_COUNTDOWN_FRAMES (4),
        .C_FREEZE_FRAMES    (2),
        .C_LEVEL_MAX        (2)
    ) dut (
        .i_Clk          (clk),
        .i_Rst_L        (rst_n),
        .i_Frame_Tick   (frame_tick),
        .i_All_Switch   (all_switch),
        .i_Has_Collided (has_collided),
        .i_Level_Up     (level_up),
        .o_Game_Active  (game_active),
        .o_Respawn      (respawn),
        .o_Freeze       (freeze),
        .o_Game_Over    (game_over),
        .o_Lives        (lives),
        .o_Level        (level),
        .o_State        (state)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input int got, input int exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0d expected %0d", tag, got, exp);
        end
    endtask

    // Advance n clock edges; outputs are sampled 1 ns after the last edge.
    task automatic step(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic frame();
        frame_tick = 1'b1;
        step(1);
        frame_tick = 1'b0;
    endtask

    // Switch press edge; leaves the switches held.
    task automatic press();
        all_switch = 1'b1;
        step(1);
    endtask

    task automatic release_sw();
        all_switch = 1'b0;
        step(1);
    endtask

    // Four frames of countdown ending in RUNNING.
    task automatic run_countdown(input string tag);
        for (int i = 0; i < 3; i++) begin
            frame();
        end
        check({tag, "_cd_state_before_last"}, int'(state), 1);
        frame();
        check({tag, "_cd_state"}, int'(state), 2);
        check({tag, "_cd_active"}, int'(game_active), 1);
    endtask

    initial begin
        rst_n        = 1'b0;
        frame_tick   = 1'b0;
        all_switch   = 1'b1;
        has_collided = 1'b0;
        level_up     = 1'b0;

        // Scenario 1: reset with switches held, then release and press.
        step(2);
        check("rst_state", int'(state), 0);
        check("rst_lives", int'(lives), 3);
        check("rst_level", int'(level), 0);
        check("rst_active", int'(game_active), 0);
        check("rst_respawn", int'(respawn), 0);
        check("rst_freeze", int'(freeze), 0);
        check("rst_gameover", int'(game_over), 0);
        rst_n = 1'b1;
        step(3);
        check("held_no_start", int'(state), 0);
        frame();
        check("idle_tick_ignored", int'(state), 0);
        release_sw();
        check("release_idle", int'(state), 0);
        press();
        check("start_state", int'(state), 1);
        check("start_respawn", int'(respawn), 1);
        release_sw();
        check("respawn_one_cycle", int'(respawn), 0);
        check("cd_no_tick_hold", int'(state), 1);
        frame();
        has_collided = 1'b1;
        frame();
        has_collided = 1'b0;
        check("cd_collision_ignored_lives", int'(lives), 3);
        check("cd_collision_ignored_state", int'(state), 1);
        frame();
        check("cd_third_tick", int'(state), 1);
        frame();
        check("s1_running", int'(state), 2);
        check("s1_active", int'(game_active), 1);
        step(3);
        check("running_no_tick_effect", int'(state), 2);

        // Scenario 3: three level-ups; level saturates at 2.
        for (int k = 0; k < 3; k++) begin
            level_up = 1'b1;
            step(1);
            level_up = 1'b0;
            check($sformatf("lvl%0d_state", k), int'(state), 4);
            check($sformatf("lvl%0d_level", k), int'(level), (k == 0) ? 1 : 2);
            check($sformatf("lvl%0d_freeze", k), int'(freeze), 1);
            check($sformatf("lvl%0d_active", k), int'(game_active), 0);
            check($sformatf("lvl%0d_lives", k), int'(lives), 3);
            step(2);
            check($sformatf("lvl%0d_freeze_no_tick", k), int'(freeze), 1);
            frame();
            check($sformatf("lvl%0d_freeze_tick1", k), int'(freeze), 1);
            frame();
            check($sformatf("lvl%0d_freeze_tick2", k), int'(freeze), 0);
            check($sformatf("lvl%0d_to_cd", k), int'(state), 1);
            check($sformatf("lvl%0d_respawn", k), int'(respawn), 1);
            run_countdown($sformatf("lvl%0d", k));
        end

        // Scenario 4: collision and level-up together; collision wins.
        has_collided = 1'b1;
        level_up     = 1'b1;
        step(1);
        has_collided = 1'b0;
        level_up     = 1'b0;
        check("both_state", int'(state), 3);
        check("both_lives", int'(lives), 2);
        check("both_level", int'(level), 2);
        check("both_freeze", int'(freeze), 1);
        frame();
        frame();
        check("both_to_cd", int'(state), 1);
        check("both_respawn", int'(respawn), 1);
        run_countdown("both");

        // Scenario 2: remaining collisions run lives down to zero.
        has_collided = 1'b1;
        step(1);
        has_collided = 1'b0;
        check("col2_state", int'(state), 3);
        check("col2_lives", int'(lives), 1);
        frame();
        frame();
        check("col2_to_cd", int'(state), 1);
        run_countdown("col2");
        has_collided = 1'b1;
        step(1);
        has_collided = 1'b0;
        check("col3_state", int'(state), 5);
        check("col3_lives", int'(lives), 0);
        check("col3_gameover", int'(game_over), 1);
        check("col3_active", int'(game_active), 0);
        check("col3_freeze", int'(freeze), 0);
        has_collided = 1'b1;
        frame();
        has_collided = 1'b0;
        check("go_collision_no_underflow", int'(lives), 0);
        check("go_hold", int'(state), 5);

        // Scenario 5: two separate presses needed from GAME_OVER.
        press();
        check("go_press_state", int'(state), 0);
        check("go_press_lives", int'(lives), 3);
        check("go_press_level", int'(level), 0);
        check("go_press_gameover", int'(game_over), 0);
        check("go_press_no_respawn", int'(respawn), 0);
        step(2);
        check("go_held_stays_idle", int'(state), 0);
        release_sw();
        press();
        check("second_press_state", int'(state), 1);
        check("second_press_respawn", int'(respawn), 1);
        release_sw();

        // Scenario 6: reset two ticks into COUNTDOWN.
        frame();
        frame();
        check("mid_cd_state", int'(state), 1);
        rst_n = 1'b0;
        step(1);
        check("mid_rst_state", int'(state), 0);
        check("mid_rst_lives", int'(lives), 3);
        check("mid_rst_level", int'(level), 0);
        check("mid_rst_active", int'(game_active), 0);
        check("mid_rst_respawn", int'(respawn), 0);
        check("mid_rst_freeze", int'(freeze), 0);
        check("mid_rst_gameover", int'(game_over), 0);
        rst_n = 1'b1;
        for (int i = 0; i < 5; i++) begin
            frame();
        end
        check("post_rst_state", int'(state), 0);
        check("post_rst_active", int'(game_active), 0);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
